// File: rtl/led_scan_ctrl.sv
// Row-scanning controller for a 32-row HUB-style LED panel: reads one row of
// RGB565 pixels from a frame buffer, shifts it out, latches it and shows it.
module led_scan_ctrl #(
  parameter int COL_NUM_LOG2 = 7,
  parameter int OE_CYCLES    = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      scan_enable,
  output logic                      ram_rd_en,
  output logic [COL_NUM_LOG2+4:0]   ram_rd_addr,
  input  logic [15:0]               ram_rd_dat,
  output logic [2:0]                led_dat,
  output logic                      led_clk,
  output logic                      led_lat,
  output logic                      led_oe_n,
  output logic [4:0]                led_row,
  output logic                      frame_done,
  output logic [2:0]                state
);

  // state    | meaning
  // IDLE     | panel blanked, waiting for scan_enable
  // FETCH    | frame-buffer read strobe for the current column
  // SHIFT_LO | pixel data returns, captured into led_dat, led_clk low
  // SHIFT_HI | led_clk high, drivers shift the pixel in
  // LATCH    | one-cycle latch pulse, displayed row address updated
  // DISPLAY  | outputs enabled for OE_CYCLES cycles
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    LATCH    = 3'd4,
    DISPLAY  = 3'd5
  } state_t;

  localparam logic [COL_NUM_LOG2-1:0] COL_LAST = '1;
  localparam logic [COL_NUM_LOG2-1:0] COL_ONE  = COL_NUM_LOG2'(1);
  localparam logic [COL_NUM_LOG2-1:0] COL_ZERO = '0;
  localparam logic [15:0]             OE_LAST  = 16'(OE_CYCLES - 1);
  localparam logic [15:0]             OE_PRE   = 16'(OE_CYCLES - 2);

  logic [2:0]              state_r;
  logic [4:0]              row;
  logic [COL_NUM_LOG2-1:0] col;
  logic [15:0]             oe_cnt;
  logic [4:0]              row_inc;
  logic [COL_NUM_LOG2-1:0] col_inc;
  logic                    unused_dat;

  assign state      = state_r;
  assign row_inc    = row + 5'd1;
  assign col_inc    = col + COL_ONE;
  assign unused_dat = ^{ram_rd_dat[14:11], ram_rd_dat[9:5], ram_rd_dat[3:0]};

  // Outputs are loaded together with the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      row         <= '0;
      col         <= '0;
      oe_cnt      <= '0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      led_dat     <= '0;
      led_clk     <= 1'b0;
      led_lat     <= 1'b0;
      led_oe_n    <= 1'b1;
      led_row     <= '0;
      frame_done  <= 1'b0;
    end else begin
      ram_rd_en  <= 1'b0;
      led_lat    <= 1'b0;
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          led_oe_n <= 1'b1;
          led_clk  <= 1'b0;
          if (scan_enable) begin
            state_r     <= FETCH;
            col         <= '0;
            ram_rd_en   <= 1'b1;
            ram_rd_addr <= {row, COL_ZERO};
          end
        end
        FETCH: begin
          led_clk <= 1'b0;
          state_r <= SHIFT_LO;
        end
        SHIFT_LO: begin
          led_dat <= {ram_rd_dat[15], ram_rd_dat[10], ram_rd_dat[4]};
          led_clk <= 1'b1;
          state_r <= SHIFT_HI;
        end
        SHIFT_HI: begin
          led_clk <= 1'b0;
          if (col == COL_LAST) begin
            state_r <= LATCH;
            led_lat <= 1'b1;
            led_row <= row;
          end else begin
            col         <= col_inc;
            state_r     <= FETCH;
            ram_rd_en   <= 1'b1;
            ram_rd_addr <= {row, col_inc};
          end
        end
        LATCH: begin
          state_r  <= DISPLAY;
          oe_cnt   <= '0;
          led_oe_n <= 1'b0;
          if (OE_CYCLES == 1 && row == 5'd31) frame_done <= 1'b1;
        end
        DISPLAY: begin
          oe_cnt <= oe_cnt + 16'd1;
          // frame_done is set one cycle early so it coincides with the exit cycle
          if (oe_cnt == OE_PRE && row == 5'd31) frame_done <= 1'b1;
          if (oe_cnt == OE_LAST) begin
            row      <= row_inc;
            col      <= '0;
            led_oe_n <= 1'b1;
            if (scan_enable) begin
              state_r     <= FETCH;
              ram_rd_en   <= 1'b1;
              ram_rd_addr <= {row_inc, COL_ZERO};
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          led_oe_n <= 1'b1;
          led_clk  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with a 4-column panel and 4-cycle display.
module tb_led_scan_ctrl;
  localparam int CL = 2;
  localparam int OE = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          scan_enable;
  logic          ram_rd_en;
  logic [CL+4:0] ram_rd_addr;
  logic [15:0]   ram_rd_dat = '0;
  logic [2:0]    led_dat;
  logic          led_clk;
  logic          led_lat;
  logic          led_oe_n;
  logic [4:0]    led_row;
  logic          frame_done;
  logic [2:0]    state;

  logic [15:0] ram [0:127];

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  logic [6:0]  addr_q[$];
  int          rdc_q[$];
  logic [2:0]  clk_q[$];
  int          lat_q[$];
  logic [4:0]  latrow_q[$];
  int          fd_q[$];
  int          oe_low = 0;
  int          rd_b2b = 0;
  logic        prev_rd = 1'b0;
  logic        prev_clk = 1'b0;

  led_scan_ctrl #(.COL_NUM_LOG2(CL), .OE_CYCLES(OE)) dut (
    .clk(clk), .rst_n(rst_n), .scan_enable(scan_enable),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_dat(ram_rd_dat),
    .led_dat(led_dat), .led_clk(led_clk), .led_lat(led_lat),
    .led_oe_n(led_oe_n), .led_row(led_row), .frame_done(frame_done),
    .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_rd_en) ram_rd_dat <= ram[ram_rd_addr];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] rgb(input logic [15:0] d);
    return {d[15], d[10], d[4]};
  endfunction

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_state"}, state, 0);
    check({pfx, "_rd_en"}, ram_rd_en, 0);
    check({pfx, "_rd_addr"}, ram_rd_addr, 0);
    check({pfx, "_led_dat"}, led_dat, 0);
    check({pfx, "_led_clk"}, led_clk, 0);
    check({pfx, "_led_lat"}, led_lat, 0);
    check({pfx, "_oe_n"}, led_oe_n, 1);
    check({pfx, "_led_row"}, led_row, 0);
    check({pfx, "_frame_done"}, frame_done, 0);
  endtask

  // Observe the outputs 1 time unit after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (ram_rd_en) begin
      addr_q.push_back(ram_rd_addr);
      rdc_q.push_back(cyc);
      if (prev_rd) rd_b2b++;
    end
    prev_rd = ram_rd_en;
    if (led_clk && !prev_clk) clk_q.push_back(led_dat);
    prev_clk = led_clk;
    if (led_lat) begin
      lat_q.push_back(cyc);
      latrow_q.push_back(led_row);
    end
    if (!led_oe_n) oe_low++;
    if (frame_done) fd_q.push_back(cyc);
  end

  initial begin
    int b1, cb, lb, o0, fb, bad, n, l4, o4;
    logic [2:0] exp_px [4];
    exp_px[0] = 3'b100; exp_px[1] = 3'b010; exp_px[2] = 3'b001; exp_px[3] = 3'b111;

    for (int i = 0; i < 128; i++) ram[i] = 16'(i * 755 + 4369);
    ram[0] = 16'hF800; ram[1] = 16'h07E0; ram[2] = 16'h001F; ram[3] = 16'hFFFF;

    rst_n = 1'b0;
    scan_enable = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");

    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_state", state, 0);
    check("idle_no_read", addr_q.size(), 0);
    check("idle_oe_n", led_oe_n, 1);

    // Test 1/2: first row timing and pixel data
    b1 = addr_q.size(); cb = clk_q.size(); lb = lat_q.size(); o0 = oe_low; fb = fd_q.size();
    scan_enable = 1'b1;
    for (int i = 0; i < 200 && addr_q.size() < b1 + 5; i++) @(negedge clk);
    check("t1_reads_seen", addr_q.size() >= b1 + 5, 1);
    if (addr_q.size() >= b1 + 5) begin
      for (int j = 0; j < 4; j++) check($sformatf("t1_addr%0d", j), addr_q[b1+j], j);
      bad = 0;
      for (int j = 1; j < 4; j++) if (rdc_q[b1+j] - rdc_q[b1+j-1] != 3) bad++;
      check("t1_pixel_spacing", bad, 0);
      check("t1_row_period", rdc_q[b1+4] - rdc_q[b1], 17);
      check("t1_next_addr", addr_q[b1+4], 4);
      check("t1_clk_edges", clk_q.size() - cb, 4);
      for (int j = 0; j < 4; j++) check($sformatf("t2_led_dat%0d", j), clk_q[cb+j], exp_px[j]);
      check("t1_lat_count", lat_q.size() - lb, 1);
      check("t1_lat_time", lat_q[lb] - rdc_q[b1], 12);
      check("t1_oe_low", oe_low - o0, 4);
    end

    // Test 3: full frame
    for (int i = 0; i < 1300 && fd_q.size() < fb + 2; i++) @(negedge clk);
    check("t3_frames_seen", fd_q.size() >= fb + 2, 1);
    if (fd_q.size() >= fb + 2) begin
      check("t3_fd_first", fd_q[fb] - rdc_q[b1], 543);
      check("t3_fd_period", fd_q[fb+1] - fd_q[fb], 544);
      for (int j = 0; j < 4; j++) check($sformatf("t3_row31_addr%0d", j), addr_q[b1+124+j], 124 + j);
      check("t3_wrap_addr", addr_q[b1+128], 0);
      bad = 0;
      for (int j = 0; j < 32; j++) if (latrow_q[lb+j] != 5'(j)) bad++;
      check("t3_led_row_seq", bad, 0);
      bad = 0;
      for (int j = 0; j < 128; j++) if (clk_q[cb+j] != rgb(ram[j])) bad++;
      check("t3_pixel_data", bad, 0);
    end
    check("t3_rd_en_b2b", rd_b2b, 0);

    // Test 4: drop scan_enable during row 5
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = addr_q.size();
    for (int i = 0; i < 300 && !(addr_q.size() > n && addr_q[$] == 7'd21); i++) @(negedge clk);
    check("t4_row5_reached", addr_q.size() > n && addr_q[$] == 7'd21, 1);
    scan_enable = 1'b0;
    l4 = lat_q.size(); o4 = oe_low;
    for (int i = 0; i < 60 && state != 3'd0; i++) @(negedge clk);
    check("t4_idle_reached", state, 0);
    check("t4_idle_oe_n", led_oe_n, 1);
    check("t4_last_addr", addr_q[$], 23);
    check("t4_lat_count", lat_q.size() - l4, 1);
    check("t4_lat_row", latrow_q[$], 5);
    check("t4_oe_low", oe_low - o4, 4);
    n = addr_q.size();
    repeat (5) @(negedge clk);
    check("t4_idle_hold", state, 0);
    check("t4_no_reads", addr_q.size() - n, 0);
    scan_enable = 1'b1;
    for (int i = 0; i < 10 && addr_q.size() == n; i++) @(negedge clk);
    check("t4_resume_addr", addr_q[$], 24);

    // Test 5: reset during row 10 display
    for (int i = 0; i < 400 && !(state == 3'd5 && led_row == 5'd10); i++) @(negedge clk);
    check("t5_row10_display", state == 3'd5 && led_row == 5'd10, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("t5");
    rst_n = 1'b1;
    n = addr_q.size();
    for (int i = 0; i < 10 && addr_q.size() == n; i++) @(negedge clk);
    check("t5_restart_addr", addr_q[$], 0);

    // Test 6: illegal encodings
    repeat (5) @(negedge clk);
    force dut.state_r = 3'd6;
    #1;
    release dut.state_r;
    @(negedge clk);
    check("t6_illegal6", state, 0);
    check("t6_oe_n", led_oe_n, 1);
    repeat (3) @(negedge clk);
    force dut.state_r = 3'd7;
    #1;
    release dut.state_r;
    @(negedge clk);
    check("t6_illegal7", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
